sha3_seq_ctrl: RTL and testbench

Top-level sequencer for the SHA3 core. It accepts message words on an AXI-Stream slave and writes them, indexed, into the absorb buffer. It generates the pad10*1 words, launches the 24-round permutation once per rate block, then drives the output serializer (Ready/TUSER/Mode) until that serializer reports Last.

---
 rtl/sha3_seq_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_sha3_seq_ctrl.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_seq_ctrl.sv
// SHA3 top-level sequencer: absorb, pad10*1, permute, squeeze.
// Optional permutation timeout guarded by SHA3_SEQ_TIMEOUT_EN.
module sha3_seq_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int PERM_TIMEOUT = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic                  S_TLAST,
  input  logic [1:0]            S_TUSER,
  input  logic                  CFG_MODE,
  output logic                  STATE_CLR,
  output logic                  ABS_WE,
  output logic [7:0]            ABS_IDX,
  output logic [DATA_WIDTH-1:0] ABS_DATA,
  output logic                  PERM_START,
  input  logic                  PERM_DONE,
  output logic                  SQ_READY,
  output logic [1:0]            SQ_TUSER,
  output logic                  SQ_MODE,
  input  logic                  SQ_LAST,
  output logic                  DONE,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    IDLE, ABSORB, PAD, PERM, SQUEEZE, FIN
  } state_t;

  localparam logic [7:0] RW0 = 8'(1152 / DATA_WIDTH);
  localparam logic [7:0] RW1 = 8'(1088 / DATA_WIDTH);
  localparam logic [7:0] RW2 = 8'(832 / DATA_WIDTH);
  localparam logic [7:0] RW3 = 8'(576 / DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] PAD_LO =
    DATA_WIDTH'(8'h06);
  localparam logic [DATA_WIDTH-1:0] PAD_HI =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [1:0] var_q, var_d;
  logic       mode_q, mode_d;
  logic       pend_q, pend_d;
  logic       fin_q, fin_d;
  logic       pfirst_q, pfirst_d;
  logic       pstart_q, pstart_d;
  logic       tmo;
  logic [7:0] last_idx;
  logic [1:0] var_sel;

  // In IDLE the block size must follow the variant on the bus.
  assign var_sel = (state_q == IDLE) ? S_TUSER : var_q;

  always_comb begin
    last_idx = RW0 - 8'd1;
    unique case (var_sel)
      2'd0: last_idx = RW0 - 8'd1;
      2'd1: last_idx = RW1 - 8'd1;
      2'd2: last_idx = RW2 - 8'd1;
      2'd3: last_idx = RW3 - 8'd1;
    endcase
  end

`ifdef SHA3_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(PERM_TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic          err_q;

  assign tmo = (state_q == PERM) && !PERM_DONE &&
               (tcnt_q == TW'(PERM_TIMEOUT - 1));
  assign ERR = err_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_q == PERM) ? tcnt_q + 1'b1 : '0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign ERR = (PERM_TIMEOUT < 0);
`endif

  assign SQ_TUSER = var_q;
  assign SQ_MODE  = mode_q;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    var_d      = var_q;
    mode_d     = mode_q;
    pend_d     = pend_q;
    fin_d      = fin_q;
    pfirst_d   = pfirst_q;
    pstart_d   = pstart_q;
    S_TREADY   = 1'b0;
    STATE_CLR  = 1'b0;
    ABS_WE     = 1'b0;
    ABS_IDX    = 8'd0;
    ABS_DATA   = '0;
    PERM_START = 1'b0;
    SQ_READY   = 1'b0;
    DONE       = 1'b0;
    unique case (state_q)
      IDLE: begin
        S_TREADY = ARESETN;
        if (S_TVALID && ARESETN) begin
          STATE_CLR = 1'b1;
          ABS_WE    = 1'b1;
          ABS_DATA  = S_TDATA;
          var_d     = S_TUSER;
          mode_d    = CFG_MODE;
          wcnt_d    = 8'd1;
          pend_d    = 1'b0;
          fin_d     = 1'b0;
          if (S_TLAST) begin
            state_d  = PAD;
            pfirst_d = 1'b1;
          end else begin
            state_d = ABSORB;
          end
        end
      end
      ABSORB: begin
        S_TREADY = 1'b1;
        if (S_TVALID) begin
          ABS_WE   = 1'b1;
          ABS_IDX  = wcnt_q;
          ABS_DATA = S_TDATA;
          wcnt_d   = wcnt_q + 8'd1;
          if (wcnt_q == last_idx) begin
            state_d  = PERM;
            pstart_d = 1'b1;
            pend_d   = S_TLAST;
          end else if (S_TLAST) begin
            state_d  = PAD;
            pfirst_d = 1'b1;
          end
        end
      end
      PAD: begin
        ABS_WE   = 1'b1;
        ABS_IDX  = wcnt_q;
        ABS_DATA = (pfirst_q ? PAD_LO : '0) |
                   ((wcnt_q == last_idx) ? PAD_HI : '0);
        pfirst_d = 1'b0;
        wcnt_d   = wcnt_q + 8'd1;
        if (wcnt_q == last_idx) begin
          state_d  = PERM;
          pstart_d = 1'b1;
          fin_d    = 1'b1;
        end
      end
      PERM: begin
        PERM_START = pstart_q;
        pstart_d   = 1'b0;
        if (PERM_DONE) begin
          wcnt_d = 8'd0;
          if (fin_q) begin
            fin_d   = 1'b0;
            state_d = SQUEEZE;
          end else if (pend_q) begin
            pend_d   = 1'b0;
            pfirst_d = 1'b1;
            state_d  = PAD;
          end else begin
            state_d = ABSORB;
          end
        end else if (tmo) begin
          fin_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SQUEEZE: begin
        SQ_READY = 1'b1;
        if (SQ_LAST) state_d = FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      wcnt_q   <= 8'd0;
      var_q    <= 2'd0;
      mode_q   <= 1'b0;
      pend_q   <= 1'b0;
      fin_q    <= 1'b0;
      pfirst_q <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      var_q    <= var_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      fin_q    <= fin_d;
      pfirst_q <= pfirst_d;
      pstart_q <= pstart_d;
    end
  end

endmodule

// File: tb/tb_sha3_seq_ctrl.sv
// Directed self-checking bench for sha3_seq_ctrl (DATA_WIDTH=16).
// Timeout scenario runs only when SHA3_SEQ_TIMEOUT_EN is defined.
module tb_sha3_seq_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [15:0] S_TDATA = '0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic        S_TLAST = 1'b0;
  logic [1:0]  S_TUSER = '0;
  logic        CFG_MODE = 1'b0;
  logic        STATE_CLR;
  logic        ABS_WE;
  logic [7:0]  ABS_IDX;
  logic [15:0] ABS_DATA;
  logic        PERM_START;
  logic        PERM_DONE = 1'b0;
  logic        SQ_READY;
  logic [1:0]  SQ_TUSER;
  logic        SQ_MODE;
  logic        SQ_LAST = 1'b0;
  logic        DONE;
  logic        ERR;

  sha3_seq_ctrl #(.DATA_WIDTH(16), .PERM_TIMEOUT(64)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID),
    .S_TREADY(S_TREADY), .S_TLAST(S_TLAST),
    .S_TUSER(S_TUSER), .CFG_MODE(CFG_MODE),
    .STATE_CLR(STATE_CLR), .ABS_WE(ABS_WE),
    .ABS_IDX(ABS_IDX), .ABS_DATA(ABS_DATA),
    .PERM_START(PERM_START), .PERM_DONE(PERM_DONE),
    .SQ_READY(SQ_READY), .SQ_TUSER(SQ_TUSER),
    .SQ_MODE(SQ_MODE), .SQ_LAST(SQ_LAST),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_clr = 0;
  int rdy_viol = 0;
  int sq_seen = 0;
  bit in_perm = 0;
  bit perm_auto = 1;
  int perm_lat = 4;
  logic [7:0]  widx[$];
  logic [15:0] wdat[$];
  logic [7:0]  eidx[$];
  logic [15:0] edat[$];

  always @(negedge ACLK) begin
    if (ABS_WE) begin
      widx.push_back(ABS_IDX);
      wdat.push_back(ABS_DATA);
    end
    if (STATE_CLR) n_clr++;
    if (SQ_READY) sq_seen++;
    if (PERM_START) begin
      n_start++;
      in_perm = 1;
    end
    if (in_perm && S_TREADY) rdy_viol++;
    if (PERM_DONE) in_perm = 0;
  end

  initial begin
    forever begin
      @(negedge ACLK);
      if (PERM_START && perm_auto) begin
        repeat (perm_lat) @(posedge ACLK);
        #1 PERM_DONE = 1'b1;
        @(posedge ACLK);
        #1 PERM_DONE = 1'b0;
      end
    end
  end

  function automatic int rate_of(input int v);
    case (v)
      0: return 72;
      1: return 68;
      2: return 52;
      default: return 36;
    endcase
  endfunction

  function automatic void build_expect(input int n, input int v);
    int r;
    int s;
    logic [15:0] d;
    r = rate_of(v);
    eidx.delete();
    edat.delete();
    for (int i = 0; i < n; i++) begin
      eidx.push_back(8'(i % r));
      edat.push_back(16'hA000 + 16'(i));
    end
    s = n % r;
    for (int j = s; j < r; j++) begin
      d = 16'h0000;
      if (j == s) d = d | 16'h0006;
      if (j == r - 1) d = d | 16'h8000;
      eidx.push_back(8'(j));
      edat.push_back(d);
    end
  endfunction

  function automatic int log_errs(output int first);
    int e = 0;
    first = -1;
    for (int i = 0; i < widx.size() && i < eidx.size(); i++) begin
      if (widx[i] !== eidx[i] || wdat[i] !== edat[i]) begin
        if (first < 0) first = i;
        e++;
      end
    end
    return e;
  endfunction

  task automatic clear_log();
    widx.delete();
    wdat.delete();
    n_start = 0;
    n_clr = 0;
    rdy_viol = 0;
    sq_seen = 0;
  endtask

  task automatic do_reset();
    #1 ARESETN = 1'b0;
    S_TVALID = 1'b0;
    S_TLAST = 1'b0;
    SQ_LAST = 1'b0;
    PERM_DONE = 1'b0;
    in_perm = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic send_msg(input int n, input int v,
                          input bit md, input bit gaps,
                          output bit stuck);
    int k;
    stuck = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          S_TVALID = 1'b0;
          @(posedge ACLK);
          #1;
        end
      end
      S_TVALID = 1'b1;
      S_TDATA  = 16'hA000 + 16'(i);
      S_TLAST  = (i == n - 1);
      S_TUSER  = (i == 0) ? 2'(v) : ~2'(v);
      CFG_MODE = (i == 0) ? md : ~md;
      k = 0;
      @(negedge ACLK);
      while (!S_TREADY && k < 2000) begin
        @(negedge ACLK);
        k++;
      end
      if (k >= 2000) stuck = 1;
      @(posedge ACLK);
      #1;
    end
    S_TVALID = 1'b0;
    S_TLAST = 1'b0;
  endtask

  task automatic squeeze(output bit ok, output logic [1:0] tu,
                         output logic md, output logic dn,
                         output logic rl, output logic idl);
    int k = 0;
    dn = 0;
    rl = 0;
    idl = 0;
    @(negedge ACLK);
    while (!SQ_READY && k < 3000) begin
      @(negedge ACLK);
      k++;
    end
    ok = SQ_READY;
    tu = SQ_TUSER;
    md = SQ_MODE;
    if (ok) begin
      @(posedge ACLK);
      #1 SQ_LAST = 1'b1;
      @(posedge ACLK);
      #1 SQ_LAST = 1'b0;
      @(negedge ACLK);
      dn = DONE;
      rl = !SQ_READY;
      @(negedge ACLK);
      idl = S_TREADY && !SQ_READY && !DONE;
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    logic [33:0] ov;
    #1 ARESETN = 1'b0;
    S_TVALID = 1'b1;
    @(negedge ACLK);
    ov = {S_TREADY, STATE_CLR, ABS_WE, ABS_IDX, ABS_DATA,
          PERM_START, SQ_READY, SQ_TUSER, SQ_MODE, DONE, ERR};
    n_chk++;
    if (ov !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h want 0", ov);
    end
    S_TVALID = 1'b0;
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    ov = {S_TREADY, STATE_CLR, ABS_WE, ABS_IDX, ABS_DATA,
          PERM_START, SQ_READY, SQ_TUSER, SQ_MODE, DONE, ERR};
    n_chk++;
    if (ov !== {1'b1, 33'd0}) begin
      n_fail++;
      $display("FAIL idle_outs got %h want %h", ov, {1'b1, 33'd0});
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_v1_short();
    bit st, ok;
    logic [1:0] tu;
    logic md, dn, rl, idl;
    int e, f;
    clear_log();
    perm_lat = 5;
    send_msg(3, 1, 1'b1, 1'b0, st);
    squeeze(ok, tu, md, dn, rl, idl);
    build_expect(3, 1);
    e = log_errs(f);
    n_chk++;
    if (st || !ok) begin
      n_fail++;
      $display("FAIL v1_squeeze stuck=%0d ready=%0d want 0/1", st, ok);
    end
    n_chk++;
    if (tu !== 2'd1 || md !== 1'b1) begin
      n_fail++;
      $display("FAIL v1_tuser_mode got %0d/%0d want 1/1", tu, md);
    end
    n_chk++;
    if (dn !== 1'b1 || rl !== 1'b1 || idl !== 1'b1) begin
      n_fail++;
      $display("FAIL v1_done done=%0d rdylow=%0d idle=%0d want 1/1/1",
               dn, rl, idl);
    end
    n_chk++;
    if (widx.size() !== 68 || e !== 0) begin
      n_fail++;
      $display("FAIL v1_writes n=%0d err=%0d first=%0d want 68/0",
               widx.size(), e, f);
    end
    n_chk++;
    if (n_start !== 1 || n_clr !== 1) begin
      n_fail++;
      $display("FAIL v1_pulses start=%0d clr=%0d want 1/1",
               n_start, n_clr);
    end
  endtask

  task automatic test_v3_both_bits();
    bit st, ok;
    logic [1:0] tu;
    logic md, dn, rl, idl;
    int e, f;
    clear_log();
    perm_lat = 3;
    send_msg(35, 3, 1'b0, 1'b0, st);
    squeeze(ok, tu, md, dn, rl, idl);
    build_expect(35, 3);
    e = log_errs(f);
    n_chk++;
    if (!ok || tu !== 2'd3 || md !== 1'b0 || dn !== 1'b1) begin
      n_fail++;
      $display("FAIL v3_squeeze ok=%0d tu=%0d md=%0d dn=%0d want 1/3/0/1",
               ok, tu, md, dn);
    end
    n_chk++;
    if (widx.size() !== 36 || e !== 0) begin
      n_fail++;
      $display("FAIL v3_writes n=%0d err=%0d first=%0d want 36/0",
               widx.size(), e, f);
    end
    n_chk++;
    if (wdat.size() < 36 || wdat[35] !== 16'h8006) begin
      n_fail++;
      $display("FAIL v3_idx35 got %h want 8006",
               (wdat.size() > 35) ? wdat[35] : 16'hxxxx);
    end
    n_chk++;
    if (n_start !== 1) begin
      n_fail++;
      $display("FAIL v3_perm_count got %0d want 1", n_start);
    end
  endtask

  task automatic test_v0_full_block();
    bit st, ok;
    logic [1:0] tu;
    logic md, dn, rl, idl;
    int e, f;
    clear_log();
    perm_lat = 2;
    send_msg(72, 0, 1'b1, 1'b0, st);
    squeeze(ok, tu, md, dn, rl, idl);
    build_expect(72, 0);
    e = log_errs(f);
    n_chk++;
    if (!ok || tu !== 2'd0 || md !== 1'b1) begin
      n_fail++;
      $display("FAIL v0_squeeze ok=%0d tu=%0d md=%0d want 1/0/1",
               ok, tu, md);
    end
    n_chk++;
    if (widx.size() !== 144 || e !== 0) begin
      n_fail++;
      $display("FAIL v0_writes n=%0d err=%0d first=%0d want 144/0",
               widx.size(), e, f);
    end
    n_chk++;
    if (n_start !== 2) begin
      n_fail++;
      $display("FAIL v0_perm_count got %0d want 2", n_start);
    end
  endtask

  task automatic test_v2_gaps();
    bit st, ok;
    logic [1:0] tu;
    logic md, dn, rl, idl;
    int e, f;
    clear_log();
    perm_lat = 30;
    send_msg(60, 2, 1'b0, 1'b1, st);
    squeeze(ok, tu, md, dn, rl, idl);
    build_expect(60, 2);
    e = log_errs(f);
    n_chk++;
    if (st || !ok || tu !== 2'd2 || dn !== 1'b1) begin
      n_fail++;
      $display("FAIL v2_squeeze st=%0d ok=%0d tu=%0d dn=%0d want 0/1/2/1",
               st, ok, tu, dn);
    end
    n_chk++;
    if (widx.size() !== 104 || e !== 0) begin
      n_fail++;
      $display("FAIL v2_writes n=%0d err=%0d first=%0d want 104/0",
               widx.size(), e, f);
    end
    n_chk++;
    if (n_start !== 2 || rdy_viol !== 0) begin
      n_fail++;
      $display("FAIL v2_perm start=%0d rdy_in_perm=%0d want 2/0",
               n_start, rdy_viol);
    end
    perm_lat = 4;
  endtask

  task automatic test_reset_mid_pad();
    bit st, ok;
    logic [1:0] tu;
    logic md, dn, rl, idl;
    logic [33:0] ov;
    int e, f;
    clear_log();
    send_msg(1, 1, 1'b1, 1'b0, st);
    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    n_chk++;
    if (ABS_WE !== 1'b1 || S_TREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL midpad_state we=%0d rdy=%0d want 1/0",
               ABS_WE, S_TREADY);
    end
    @(posedge ACLK);
    #1 ARESETN = 1'b0;
    @(negedge ACLK);
    ov = {S_TREADY, STATE_CLR, ABS_WE, ABS_IDX, ABS_DATA,
          PERM_START, SQ_READY, SQ_TUSER, SQ_MODE, DONE, ERR};
    n_chk++;
    if (ov !== '0) begin
      n_fail++;
      $display("FAIL midpad_reset_outs got %h want 0", ov);
    end
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    clear_log();
    send_msg(1, 1, 1'b0, 1'b0, st);
    squeeze(ok, tu, md, dn, rl, idl);
    build_expect(1, 1);
    e = log_errs(f);
    n_chk++;
    if (n_clr !== 1 || widx.size() !== 68 || e !== 0) begin
      n_fail++;
      $display("FAIL after_reset clr=%0d n=%0d err=%0d first=%0d want 1/68/0",
               n_clr, widx.size(), e, f);
    end
    n_chk++;
    if (wdat.size() < 2 || wdat[1] !== 16'h0006 || md !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idx1 got %h mode=%0d want 0006/0",
               (wdat.size() > 1) ? wdat[1] : 16'hxxxx, md);
    end
  endtask

`ifdef SHA3_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit st;
    int k;
    clear_log();
    perm_auto = 0;
    send_msg(1, 3, 1'b0, 1'b0, st);
    k = 0;
    @(negedge ACLK);
    while (!PERM_START && k < 200) begin
      @(negedge ACLK);
      k++;
    end
    k = 0;
    while (!ERR && k < 200) begin
      @(negedge ACLK);
      k++;
    end
    n_chk++;
    if (k !== 64) begin
      n_fail++;
      $display("FAIL tmo_latency got %0d want 64", k);
    end
    repeat (5) @(negedge ACLK);
    n_chk++;
    if (ERR !== 1'b1 || S_TREADY !== 1'b1 || sq_seen !== 0) begin
      n_fail++;
      $display("FAIL tmo_state err=%0d rdy=%0d sq=%0d want 1/1/0",
               ERR, S_TREADY, sq_seen);
    end
    @(posedge ACLK);
    do_reset();
    perm_auto = 1;
  endtask
`endif

  initial begin
    @(posedge ACLK);
    test_reset();
    test_v1_short();
    test_v3_both_bits();
    test_v0_full_block();
    test_v2_gaps();
    test_reset_mid_pad();
`ifdef SHA3_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
